// File: rtl/pipeline_run_controller.sv
// Run/step/halt sequencer for a 5-stage pipeline; outputs are Moore, commands take effect on the accepting edge.
// Commands are refused (o_cmd_ready=0) during STEP and DRAIN. Optional cycle counter under PIPE_CTRL_CYCLE_CNT_EN.
module pipeline_run_controller #(
  parameter int DRAIN_CYCLES = 4,
  parameter int CNT_W        = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_cmd_valid,
  input  logic [1:0]       i_cmd,
  output logic             o_cmd_ready,
  input  logic             i_halt_D,
  output logic             o_pipe_en,
  output logic             o_pc_en,
  output logic             o_flush_if_id,
  output logic             o_busy,
  output logic             o_done,
  output logic [2:0]       o_state,
  output logic [CNT_W-1:0] o_cycle_cnt
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_STEP  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [1:0] CMD_RUN  = 2'b01;
  localparam logic [1:0] CMD_STEP = 2'b10;
  localparam logic [1:0] CMD_HALT = 2'b11;
  localparam logic [3:0] LP_DRAIN = DRAIN_CYCLES[3:0];

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_drain_cnt;
  logic [3:0] w_drain_nxt;
  logic       w_accept;

  assign w_accept = i_cmd_valid && o_cmd_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_drain_cnt <= 4'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_drain_cnt <= w_drain_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_drain_nxt = r_drain_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_accept && i_cmd == CMD_RUN)       w_state_nxt = S_RUN;
        else if (w_accept && i_cmd == CMD_STEP) w_state_nxt = S_STEP;
      end
      S_RUN: begin
        // A decoded halt outranks an external HALT arriving on the same edge.
        if (i_halt_D) begin
          w_state_nxt = S_DRAIN;
          w_drain_nxt = LP_DRAIN;
        end else if (w_accept && i_cmd == CMD_HALT) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_STEP: begin
        if (i_halt_D) begin
          w_state_nxt = S_DRAIN;
          w_drain_nxt = LP_DRAIN;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_DRAIN: begin
        w_drain_nxt = r_drain_cnt - 4'd1;
        if (r_drain_cnt == 4'd1) w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = S_DONE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign o_cmd_ready   = (r_state == S_IDLE) || (r_state == S_RUN) || (r_state == S_DONE);
  assign o_pipe_en     = (r_state == S_RUN) || (r_state == S_STEP) || (r_state == S_DRAIN);
  assign o_pc_en       = (r_state == S_RUN) || (r_state == S_STEP);
  // Counter still holds its load value only in the first drain cycle.
  assign o_flush_if_id = (r_state == S_DRAIN) && (r_drain_cnt == LP_DRAIN);
  assign o_busy        = o_pipe_en;
  assign o_done        = (r_state == S_DONE);
  assign o_state       = r_state;

`ifdef PIPE_CTRL_CYCLE_CNT_EN
  logic [CNT_W-1:0] r_cycle_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cycle_cnt <= '0;
    end else if (o_pipe_en && (r_cycle_cnt != {CNT_W{1'b1}})) begin
      r_cycle_cnt <= r_cycle_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign o_cycle_cnt = r_cycle_cnt;
`else
  assign o_cycle_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_run_controller.sv
// Directed bench for pipeline_run_controller: main instance (DRAIN_CYCLES=4, CNT_W=32) and a narrow one (1, 4).
module tb_pipeline_run_controller;

  // Output vector: {pipe_en, pc_en, flush, busy, done, cmd_ready, state[2:0]}
  localparam logic [8:0] O_IDLE   = 9'b0_0_0_0_0_1_000;
  localparam logic [8:0] O_RUN    = 9'b1_1_0_1_0_1_001;
  localparam logic [8:0] O_STEP   = 9'b1_1_0_1_0_0_010;
  localparam logic [8:0] O_DRAIN1 = 9'b1_0_1_1_0_0_011;
  localparam logic [8:0] O_DRAIN  = 9'b1_0_0_1_0_0_011;
  localparam logic [8:0] O_DONE   = 9'b0_0_0_0_1_1_100;

  localparam logic [1:0] C_NOP = 2'b00, C_RUN = 2'b01, C_STEP = 2'b10, C_HALT = 2'b11;

  logic i_clk = 1'b0;
  logic i_rst_n;
  logic i_cmd_valid, i_halt_D;
  logic [1:0] i_cmd;
  logic o_cmd_ready, o_pipe_en, o_pc_en, o_flush_if_id, o_busy, o_done;
  logic [2:0]  o_state;
  logic [31:0] o_cycle_cnt;

  logic n_cmd_valid, n_halt_D;
  logic [1:0] n_cmd;
  logic n_cmd_ready, n_pipe_en, n_pc_en, n_flush_if_id, n_busy, n_done;
  logic [2:0] n_state;
  logic [3:0] n_cycle_cnt;

  logic [8:0] w_obs, w_obs_n;

  int errors = 0;
  int checks = 0;

  always #5 i_clk = ~i_clk;

  pipeline_run_controller #(.DRAIN_CYCLES(4), .CNT_W(32)) u_dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_cmd_valid(i_cmd_valid), .i_cmd(i_cmd),
    .o_cmd_ready(o_cmd_ready), .i_halt_D(i_halt_D), .o_pipe_en(o_pipe_en),
    .o_pc_en(o_pc_en), .o_flush_if_id(o_flush_if_id), .o_busy(o_busy),
    .o_done(o_done), .o_state(o_state), .o_cycle_cnt(o_cycle_cnt)
  );

  pipeline_run_controller #(.DRAIN_CYCLES(1), .CNT_W(4)) u_dut_n (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_cmd_valid(n_cmd_valid), .i_cmd(n_cmd),
    .o_cmd_ready(n_cmd_ready), .i_halt_D(n_halt_D), .o_pipe_en(n_pipe_en),
    .o_pc_en(n_pc_en), .o_flush_if_id(n_flush_if_id), .o_busy(n_busy),
    .o_done(n_done), .o_state(n_state), .o_cycle_cnt(n_cycle_cnt)
  );

  assign w_obs   = {o_pipe_en, o_pc_en, o_flush_if_id, o_busy, o_done, o_cmd_ready, o_state};
  assign w_obs_n = {n_pipe_en, n_pc_en, n_flush_if_id, n_busy, n_done, n_cmd_ready, n_state};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Counter expectation depends on whether the counter is built in.
  function automatic logic [63:0] exp_cnt(input int n);
`ifdef PIPE_CTRL_CYCLE_CNT_EN
    return 64'(n);
`else
    return 64'd0;
`endif
  endfunction

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic send(input logic [1:0] c);
    i_cmd_valid = 1'b1;
    i_cmd       = c;
    tick();
    i_cmd_valid = 1'b0;
    i_cmd       = C_NOP;
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic pulse_reset(input string tag);
    i_rst_n = 1'b0;
    #2;
    check({tag, "_rst_outs"}, 64'(w_obs), 64'(O_IDLE));
    check({tag, "_rst_cnt"}, 64'(o_cycle_cnt), 64'd0);
    i_rst_n = 1'b1;
  endtask

  initial begin
    i_rst_n = 1'b0; i_cmd_valid = 1'b0; i_cmd = C_NOP; i_halt_D = 1'b0;
    n_cmd_valid = 1'b0; n_cmd = C_NOP; n_halt_D = 1'b0;
    #3;
    check("reset_outs", 64'(w_obs), 64'(O_IDLE));
    check("reset_cnt", 64'(o_cycle_cnt), 64'd0);
    check("reset_outs_n", 64'(w_obs_n), 64'(O_IDLE));
    tick();
    i_rst_n = 1'b1;

    // Single step then back to IDLE
    send(C_STEP);
    check("step_outs", 64'(w_obs), 64'(O_STEP));
    tick();
    check("step_to_idle", 64'(w_obs), 64'(O_IDLE));
    check("step_cnt", 64'(o_cycle_cnt), exp_cnt(1));
    send(C_HALT);
    check("idle_halt_stays", 64'(w_obs), 64'(O_IDLE));
    i_halt_D = 1'b1;
    tick();
    i_halt_D = 1'b0;
    check("idle_ignores_halt_D", 64'(w_obs), 64'(O_IDLE));
    check("idle_cnt_hold", 64'(o_cycle_cnt), exp_cnt(1));

    // RUN at edge 1, decoded halt at edge 10, drain of 4
    pulse_reset("pre_run");
    send(C_RUN);
    check("run_outs", 64'(w_obs), 64'(O_RUN));
    repeat (8) tick();
    check("run_edge9", 64'(w_obs), 64'(O_RUN));
    i_halt_D = 1'b1;
    tick();
    i_halt_D = 1'b0;
    check("drain_c11", 64'(w_obs), 64'(O_DRAIN1));
    for (int c = 12; c <= 14; c++) begin
      tick();
      check($sformatf("drain_c%0d", c), 64'(w_obs), 64'(O_DRAIN));
    end
    tick();
    check("done_c15", 64'(w_obs), 64'(O_DONE));
    check("done_cnt", 64'(o_cycle_cnt), exp_cnt(13));
    send(C_RUN);
    check("done_run_ignored", 64'(w_obs), 64'(O_DONE));
    check("done_cnt_hold", 64'(o_cycle_cnt), exp_cnt(13));
    pulse_reset("exit_done");
    tick();
    check("post_done_idle", 64'(w_obs), 64'(O_IDLE));

    // HALT command and decoded halt together: decoded halt wins
    send(C_RUN);
    tick();
    i_halt_D = 1'b1;
    send(C_HALT);
    i_halt_D = 1'b0;
    check("halt_prio_drain", 64'(w_obs), 64'(O_DRAIN1));
    tick();
    check("mid_drain", 64'(w_obs), 64'(O_DRAIN));
    pulse_reset("mid_drain");
    tick();
    check("after_drain_abort", 64'(w_obs), 64'(O_IDLE));

    // Pause and resume with no lost count
    pulse_reset("pre_pause");
    send(C_RUN);
    repeat (4) tick();
    send(C_HALT);
    check("pause_idle", 64'(w_obs), 64'(O_IDLE));
    check("pause_cnt", 64'(o_cycle_cnt), exp_cnt(5));
    repeat (2) tick();
    check("pause_cnt_hold", 64'(o_cycle_cnt), exp_cnt(5));
    send(C_RUN);
    check("resume_run", 64'(w_obs), 64'(O_RUN));
    check("resume_cnt", 64'(o_cycle_cnt), exp_cnt(5));
    send(C_STEP);
    check("run_step_ignored", 64'(w_obs), 64'(O_RUN));
    check("resume_cnt2", 64'(o_cycle_cnt), exp_cnt(6));
    send(C_HALT);
    send(C_STEP);
    check("step2_outs", 64'(w_obs), 64'(O_STEP));
    i_halt_D = 1'b1;
    tick();
    i_halt_D = 1'b0;
    check("step_halt_drain", 64'(w_obs), 64'(O_DRAIN1));
    check("step_halt_cnt", 64'(o_cycle_cnt), exp_cnt(8));

    // Narrow instance: counter saturation and single-cycle drain
    pulse_reset("pre_sat");
    n_cmd_valid = 1'b1;
    n_cmd       = C_RUN;
    tick();
    n_cmd_valid = 1'b0;
    repeat (20) tick();
    check("sat_run", 64'(w_obs_n), 64'(O_RUN));
    check("sat_cnt", 64'(n_cycle_cnt), exp_cnt(15));
    n_halt_D = 1'b1;
    tick();
    n_halt_D = 1'b0;
    check("drain1_flush", 64'(w_obs_n), 64'(O_DRAIN1));
    tick();
    check("drain1_done", 64'(w_obs_n), 64'(O_DONE));
    check("sat_cnt_hold", 64'(n_cycle_cnt), exp_cnt(15));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
